input_stream_loader: RTL and testbench

- Consumer end of the host input FIFO.
- After a `load_kdtree` command it pops the 11-bit word stream in a fixed order:
  - internal nodes (2 words each),
  - then leaf patches (6 words each),
  - then query patches (5 words each).
- It assembles each group into a wide record and issues one write strobe per record to the node table, leaf memory or query memory.
- Sits between the io_clk→clk async FIFO read side and the on-chip storage ahead of the search FSM.

---
 rtl/input_stream_loader_if.sv | 86 ++++++++
 rtl/input_stream_loader.sv | 199 +++++++++++++++++++
 tb/tb_input_stream_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_stream_loader_if.sv
// Bundle between the host input FIFO read side, the on-chip record stores
// and the input_stream_loader. "master" is the loader's view, "slave" is the
// view of the surrounding FIFO / storage / control logic.
// Optional: INPUT_LOADER_DIMCHK_EN adds the sticky err_bad_dim flag.
interface input_stream_loader_if #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
);
  localparam int ADDR_W  = $clog2(NUM_LEAVES);
  localparam int SLOT_W  = $clog2(LEAF_SIZE);
  localparam int QADDR_W = $clog2(NUM_QUERYS);
  localparam int REC_W   = PATCH_SIZE * DATA_WIDTH;

  // Command and FIFO read side
  logic                  load_kdtree;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rempty_n;
  logic                  fifo_deq;

  // Internal node table write port
  logic                  node_wen;
  logic [ADDR_W-1:0]     node_waddr;
  logic [DATA_WIDTH-1:0] node_dim;
  logic [DATA_WIDTH-1:0] node_median;

  // Leaf memory write port
  logic                  leaf_wen;
  logic [ADDR_W-1:0]     leaf_waddr;
  logic [SLOT_W-1:0]     leaf_slot;
  logic [REC_W-1:0]      leaf_data;
  logic [DATA_WIDTH-1:0] leaf_pidx;

  // Query memory write port
  logic                  query_wen;
  logic [QADDR_W-1:0]    query_waddr;
  logic [REC_W-1:0]      query_data;

  // Status
  logic                  kdtree_loaded;
  logic                  queries_loaded;
  logic                  busy;

`ifdef INPUT_LOADER_DIMCHK_EN
  logic                  err_bad_dim;

  modport master (
    input  load_kdtree, fifo_rdata, fifo_rempty_n,
    output fifo_deq,
    output node_wen, node_waddr, node_dim, node_median,
    output leaf_wen, leaf_waddr, leaf_slot, leaf_data, leaf_pidx,
    output query_wen, query_waddr, query_data,
    output kdtree_loaded, queries_loaded, busy, err_bad_dim
  );

  modport slave (
    output load_kdtree, fifo_rdata, fifo_rempty_n,
    input  fifo_deq,
    input  node_wen, node_waddr, node_dim, node_median,
    input  leaf_wen, leaf_waddr, leaf_slot, leaf_data, leaf_pidx,
    input  query_wen, query_waddr, query_data,
    input  kdtree_loaded, queries_loaded, busy, err_bad_dim
  );
`else
  modport master (
    input  load_kdtree, fifo_rdata, fifo_rempty_n,
    output fifo_deq,
    output node_wen, node_waddr, node_dim, node_median,
    output leaf_wen, leaf_waddr, leaf_slot, leaf_data, leaf_pidx,
    output query_wen, query_waddr, query_data,
    output kdtree_loaded, queries_loaded, busy
  );

  modport slave (
    output load_kdtree, fifo_rdata, fifo_rempty_n,
    input  fifo_deq,
    input  node_wen, node_waddr, node_dim, node_median,
    input  leaf_wen, leaf_waddr, leaf_slot, leaf_data, leaf_pidx,
    input  query_wen, query_waddr, query_data,
    input  kdtree_loaded, queries_loaded, busy
  );
`endif

endinterface

// File: rtl/input_stream_loader.sv
// input_stream_loader: consumer end of the host input FIFO. After a
// load_kdtree pulse it pops the word stream in fixed order (internal nodes,
// leaf patches, query patches), assembles each group into a record and
// issues one write strobe per record.
// Optional: INPUT_LOADER_DIMCHK_EN saturates out-of-range split dimensions
// and raises the sticky err_bad_dim flag.
module input_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
) (
  input logic                    clk,
  input logic                    rst,
  input_stream_loader_if.master  bus
);

  localparam int ADDR_W    = $clog2(NUM_LEAVES);
  localparam int SLOT_W    = $clog2(LEAF_SIZE);
  localparam int QADDR_W   = $clog2(NUM_QUERYS);
  localparam int REC_W     = PATCH_SIZE * DATA_WIDTH;
  localparam int WCNT_W    = $clog2(PATCH_SIZE + 1);
  localparam int NUM_NODES = NUM_LEAVES - 1;

  typedef enum logic [2:0] {
    IDLE,
    NODES,
    LEAVES,
    QUERIES,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WCNT_W-1:0]     word_cnt;   // words of the current group already taken
  logic [ADDR_W-1:0]     node_cnt;
  logic [ADDR_W-1:0]     leaf_cnt;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [QADDR_W-1:0]    query_cnt;
  logic [REC_W-1:0]      sreg;       // newest word enters at the top, element 0 ends in the LSBs

  logic                  active;
  logic                  accept;
  logic                  node_done;
  logic                  leaf_done;
  logic                  query_done;
  logic                  restart;
  logic [DATA_WIDTH-1:0] dim_word;

  assign restart  = bus.load_kdtree;
  assign active   = (state == NODES) || (state == LEAVES) || (state == QUERIES);
  assign bus.fifo_deq = bus.fifo_rempty_n && active;
  assign bus.busy     = active;
  // fifo_deq already requires a valid head word, so it doubles as the accept.
  assign accept   = bus.fifo_deq;

  // Final word of a group is being accepted this cycle.
  assign node_done  = accept && (state == NODES)   && (word_cnt == WCNT_W'(1));
  assign leaf_done  = accept && (state == LEAVES)  && (word_cnt == WCNT_W'(PATCH_SIZE));
  assign query_done = accept && (state == QUERIES) && (word_cnt == WCNT_W'(PATCH_SIZE - 1));

  // After one shift the dimension word of a node sits in the top element.
  assign dim_word = sreg[REC_W-1 -: DATA_WIDTH];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode: a load command restarts from any state.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    if (restart) begin
      state_nx = NODES;
    end else begin
      case (state)
        IDLE, DONE: state_nx = state;
        NODES:
          if (node_done && (node_cnt == ADDR_W'(NUM_NODES - 1)))
            state_nx = LEAVES;
        LEAVES:
          if (leaf_done && (leaf_cnt == ADDR_W'(NUM_LEAVES - 1)) &&
              (slot_cnt == SLOT_W'(LEAF_SIZE - 1)))
            state_nx = QUERIES;
        QUERIES:
          if (query_done && (query_cnt == QADDR_W'(NUM_QUERYS - 1)))
            state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Word assembly and group/record counters; a restart discards partial groups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      node_cnt  <= '0;
      leaf_cnt  <= '0;
      slot_cnt  <= '0;
      query_cnt <= '0;
      // NOTE: the shift register is a handful of flops, not a RAM, so it is
      // reset along with everything else.
      sreg      <= '0;
    end else if (restart) begin
      word_cnt  <= '0;
      node_cnt  <= '0;
      leaf_cnt  <= '0;
      slot_cnt  <= '0;
      query_cnt <= '0;
      sreg      <= '0;
    end else if (accept) begin
      sreg <= {bus.fifo_rdata, sreg[REC_W-1:DATA_WIDTH]};
      if (node_done || leaf_done || query_done) word_cnt <= '0;
      else                                      word_cnt <= word_cnt + 1'b1;
      if (node_done) node_cnt <= node_cnt + 1'b1;
      if (leaf_done) begin
        if (slot_cnt == SLOT_W'(LEAF_SIZE - 1)) begin
          slot_cnt <= '0;
          leaf_cnt <= leaf_cnt + 1'b1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end
      if (query_done) query_cnt <= query_cnt + 1'b1;
    end
  end

  // Record outputs: one-cycle strobes, address/data held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.node_wen    <= 1'b0;
      bus.node_waddr  <= '0;
      bus.node_dim    <= '0;
      bus.node_median <= '0;
      bus.leaf_wen    <= 1'b0;
      bus.leaf_waddr  <= '0;
      bus.leaf_slot   <= '0;
      bus.leaf_data   <= '0;
      bus.leaf_pidx   <= '0;
      bus.query_wen   <= 1'b0;
      bus.query_waddr <= '0;
      bus.query_data  <= '0;
    end else begin
      bus.node_wen  <= node_done  && !restart;
      bus.leaf_wen  <= leaf_done  && !restart;
      bus.query_wen <= query_done && !restart;
      if (node_done && !restart) begin
        bus.node_waddr  <= node_cnt;
`ifdef INPUT_LOADER_DIMCHK_EN
        bus.node_dim    <= (dim_word >= DATA_WIDTH'(PATCH_SIZE)) ?
                           DATA_WIDTH'(PATCH_SIZE - 1) : dim_word;
`else
        bus.node_dim    <= dim_word;
`endif
        bus.node_median <= bus.fifo_rdata;
      end
      if (leaf_done && !restart) begin
        bus.leaf_waddr <= leaf_cnt;
        bus.leaf_slot  <= slot_cnt;
        bus.leaf_data  <= sreg;
        bus.leaf_pidx  <= bus.fifo_rdata;
      end
      if (query_done && !restart) begin
        bus.query_waddr <= query_cnt;
        bus.query_data  <= {bus.fifo_rdata, sreg[REC_W-1:DATA_WIDTH]};
      end
    end
  end

  // Completion flags. A leaf strobe seen while already in QUERIES can only be
  // the final leaf, so the flag rises the cycle after it; same for queries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.kdtree_loaded  <= 1'b0;
      bus.queries_loaded <= 1'b0;
    end else if (restart) begin
      bus.kdtree_loaded  <= 1'b0;
      bus.queries_loaded <= 1'b0;
    end else begin
      if (bus.leaf_wen && (state == QUERIES)) bus.kdtree_loaded  <= 1'b1;
      if (bus.query_wen && (state == DONE))   bus.queries_loaded <= 1'b1;
    end
  end

`ifdef INPUT_LOADER_DIMCHK_EN
  // Sticky flag for a split dimension outside the patch, set with node_wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                    bus.err_bad_dim <= 1'b0;
    else if (restart)                                           bus.err_bad_dim <= 1'b0;
    else if (node_done && (dim_word >= DATA_WIDTH'(PATCH_SIZE))) bus.err_bad_dim <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_input_stream_loader.sv
// Self-checking bench for input_stream_loader. A frame of random words is
// streamed through a FIFO source; expected records, flags and pops come from
// the word index arithmetic of the stream layout.
// Optional: INPUT_LOADER_DIMCHK_EN enables the err_bad_dim checks.
module tb_input_stream_loader;

  localparam int DW = 11;
  localparam int PS = 5;
  localparam int LS = 8;
  localparam int NL = 64;
  localparam int NQ = 494;
  localparam int AW = $clog2(NL);
  localparam int SW = $clog2(LS);
  localparam int QW = $clog2(NQ);
  localparam int NODE_WORDS = 2 * (NL - 1);            // 126
  localparam int LEAF_WORDS = (PS + 1) * LS * NL;      // 3072
  localparam int Q_BASE     = NODE_WORDS + LEAF_WORDS; // 3198
  localparam int TOTAL      = Q_BASE + PS * NQ;        // 5668

  typedef struct packed {
    logic           node;
    logic           leaf;
    logic           query;
    logic [AW-1:0]  naddr;
    logic [DW-1:0]  dim;
    logic [DW-1:0]  med;
    logic [AW-1:0]  laddr;
    logic [SW-1:0]  slot;
    logic [DW-1:0]  pidx;
    logic [PS*DW-1:0] ldata;
    logic [QW-1:0]  qaddr;
    logic [PS*DW-1:0] qdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_stream_loader_if #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS),
                           .NUM_LEAVES(NL), .NUM_QUERYS(NQ)) bus ();

  input_stream_loader #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS),
                        .NUM_LEAVES(NL), .NUM_QUERYS(NQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;

  logic [DW-1:0] frame [TOTAL];
  int   ptr;       // FIFO source read pointer
  int   acc;       // words the loader should have accepted in this frame
  bit   running;   // loader expected in an active state
  exp_t e;         // strobes expected at the next sample point
  bit   exp_kdt, kdt_arm, exp_qd, qd_arm, exp_err;
  int   n_node, n_leaf, n_query;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"}, {bus.fifo_deq, bus.node_wen, bus.leaf_wen, bus.query_wen,
                          bus.kdtree_loaded, bus.queries_loaded, bus.busy}, '0);
    check({tag, ".node"}, {bus.node_waddr, bus.node_dim, bus.node_median}, '0);
    check({tag, ".leafa"}, {bus.leaf_waddr, bus.leaf_slot, bus.leaf_pidx}, '0);
    check({tag, ".leafd"}, bus.leaf_data, '0);
    check({tag, ".query"}, {bus.query_waddr, bus.query_data[PS*DW-1:32]}, '0);
    check({tag, ".queryd"}, bus.query_data[31:0], '0);
`ifdef INPUT_LOADER_DIMCHK_EN
    check({tag, ".err"}, bus.err_bad_dim, '0);
`endif
  endtask

  // Random frame with the directed groups placed at their stream positions.
  task automatic make_frame(input logic [DW-1:0] dim0);
    int base;
    for (int k = 0; k < TOTAL; k++) begin
      if (k < NODE_WORDS && (k % 2) == 0) frame[k] = DW'($urandom_range(0, PS - 1));
      else                                frame[k] = DW'($urandom);
    end
    frame[0] = dim0;
    frame[1] = 11'h7EF;
    base = NODE_WORDS + (PS + 1) * (1 * LS + 7);  // leaf 1, slot 7
    frame[base + 0] = 11'd10;
    frame[base + 1] = 11'd20;
    frame[base + 2] = 11'd30;
    frame[base + 3] = 11'd40;
    frame[base + 4] = 11'd50;
    frame[base + 5] = 11'd493;
  endtask

  // Reference: which record, if any, the k-th accepted word completes.
  task automatic classify(input int k);
    int j, p, q;
    logic [DW-1:0] d;
    if (k < NODE_WORDS) begin
      if ((k % 2) == 1) begin
        d       = frame[k - 1];
        e.node  = 1'b1;
        e.naddr = AW'(k / 2);
        e.med   = frame[k];
`ifdef INPUT_LOADER_DIMCHK_EN
        e.dim   = (int'(d) >= PS) ? DW'(PS - 1) : d;
        if (int'(d) >= PS) exp_err = 1'b1;
`else
        e.dim   = d;
`endif
      end
    end else if (k < Q_BASE) begin
      j = k - NODE_WORDS;
      if ((j % (PS + 1)) == PS) begin
        p       = j / (PS + 1);
        e.leaf  = 1'b1;
        e.laddr = AW'(p / LS);
        e.slot  = SW'(p % LS);
        e.pidx  = frame[k];
        for (int i = 0; i < PS; i++) e.ldata[i*DW +: DW] = frame[k - PS + i];
      end
    end else begin
      j = k - Q_BASE;
      if ((j % PS) == PS - 1) begin
        q       = j / PS;
        e.query = 1'b1;
        e.qaddr = QW'(q);
        for (int i = 0; i < PS; i++) e.qdata[i*DW +: DW] = frame[k - PS + 1 + i];
      end
    end
  endtask

  task automatic compare();
    check("wen", {bus.node_wen, bus.leaf_wen, bus.query_wen}, {e.node, e.leaf, e.query});
    if (e.node) check("node_rec", {bus.node_waddr, bus.node_dim, bus.node_median},
                      {e.naddr, e.dim, e.med});
    if (e.leaf) begin
      check("leaf_addr", {bus.leaf_waddr, bus.leaf_slot, bus.leaf_pidx}, {e.laddr, e.slot, e.pidx});
      check("leaf_data", bus.leaf_data, e.ldata);
    end
    if (e.query) begin
      check("query_addr", bus.query_waddr, e.qaddr);
      check("query_data", bus.query_data, e.qdata);
    end
    check("loaded", {bus.kdtree_loaded, bus.queries_loaded}, {exp_kdt, exp_qd});
    check("busy", bus.busy, running);
    check("fifo_deq", bus.fifo_deq, bus.fifo_rempty_n && running);
`ifdef INPUT_LOADER_DIMCHK_EN
    check("err_bad_dim", bus.err_bad_dim, exp_err);
`endif
    n_node  += int'(bus.node_wen);
    n_leaf  += int'(bus.leaf_wen);
    n_query += int'(bus.query_wen);
  endtask

  // Advance the reference across the coming clock edge.
  task automatic model_edge(input bit load, input bit avail);
    bit take;
    take = avail && running;
    e = '0;
    if (load) begin
      running = 1'b1;
      acc     = 0;
      exp_kdt = 1'b0; kdt_arm = 1'b0;
      exp_qd  = 1'b0; qd_arm  = 1'b0;
      exp_err = 1'b0;
      n_node = 0; n_leaf = 0; n_query = 0;
    end else begin
      exp_kdt = kdt_arm;
      exp_qd  = qd_arm;
      if (take) begin
        classify(acc);
        acc++;
        if (acc == TOTAL) running = 1'b0;
      end
      kdt_arm = (acc >= Q_BASE);
      qd_arm  = (acc >= TOTAL);
    end
  endtask

  // One clock: drive, sample at the falling edge, model, then advance FIFO.
  task automatic cycle(input bit load, input bit avail);
    logic deq_seen, vld_seen;
    bus.load_kdtree   = load;
    bus.fifo_rempty_n = avail && (ptr < TOTAL);
    bus.fifo_rdata    = frame[(ptr < TOTAL) ? ptr : 0];
    @(negedge clk);
    compare();
    deq_seen = bus.fifo_deq;
    vld_seen = bus.fifo_rempty_n;
    model_edge(load, vld_seen);
    @(posedge clk);
    #1;
    if (load)                      ptr = 0;
    else if (deq_seen && vld_seen) ptr++;
    bus.load_kdtree = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".nodes"},   n_node,  NL - 1);
    check({tag, ".leaves"},  n_leaf,  NL * LS);
    check({tag, ".queries"}, n_query, NQ);
  endtask

  initial begin
    int budget, stall_left;
    bit stalled, avail;
    vectors = 0; miscompares = 0;
    ptr = 0; acc = 0; running = 1'b0; e = '0;
    exp_kdt = 0; kdt_arm = 0; exp_qd = 0; qd_arm = 0; exp_err = 0;
    n_node = 0; n_leaf = 0; n_query = 0;
    rst = 1'b1;
    bus.load_kdtree = 1'b0; bus.fifo_rempty_n = 1'b1; bus.fifo_rdata = '0;
    make_frame(11'd3);
    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    repeat (6) cycle(1'b0, 1'b1);   // data present but no load: no pops

    // Frame A: FIFO never empty, full load.
    make_frame(11'd3);
    cycle(1'b1, 1'b1);
    budget = 20000;
    while (running && budget > 0) begin cycle(1'b0, 1'b1); budget--; end
    check("frameA.budget", running, 1'b0);
    repeat (4) cycle(1'b0, 1'b1);
    check_counts("frameA");

    // Frame B: random gaps plus a 20-cycle empty FIFO after word 3 of query 7.
    make_frame(11'd3);
    cycle(1'b1, 1'b1);
    budget = 20000; stall_left = 0; stalled = 1'b0;
    while (running && budget > 0) begin
      if (!stalled && acc == Q_BASE + 7 * PS + 3) begin stalled = 1'b1; stall_left = 20; end
      avail = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stall_left > 0) stall_left--;
      cycle(1'b0, avail);
      budget--;
    end
    check("frameB.budget", running, 1'b0);
    check("frameB.stall_seen", stalled, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    check_counts("frameB");

    // Frame C: restart with two words of leaf 10 taken, into frame D.
    make_frame(11'd3);
    cycle(1'b1, 1'b1);
    budget = 20000;
    while (acc < NODE_WORDS + (PS + 1) * LS * 10 + 2 && budget > 0) begin
      cycle(1'b0, 1'b1); budget--;
    end
    make_frame(11'd7);
    cycle(1'b1, 1'b1);
    budget = 20000;
    while (acc < Q_BASE + 100 && budget > 0) begin cycle(1'b0, 1'b1); budget--; end
    check("frameD.budget", acc >= Q_BASE + 100, 1'b1);

    // Asynchronous reset in the middle of the query section.
    bus.fifo_rempty_n = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("rst_midq");
    running = 1'b0; acc = 0; e = '0;
    exp_kdt = 0; kdt_arm = 0; exp_qd = 0; qd_arm = 0; exp_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) cycle(1'b0, 1'b1);   // no pops until the next load

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
